// File: rtl/cache_perf_monitor.sv
// cache_perf_monitor: per-channel cache access/hit/miss/stall and miss-latency statistics with registered readout
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_valid_i, req_ready_i     : per-channel request handshake (access / stall)
//   hit_i, miss_i                : per-channel lookup result, qualified by an accepted request
//   resp_valid_i                 : per-channel refill response closing the outstanding miss
//   clear_i, freeze_i            : zero all statistics / hold all statistics
//   rd_ch_i, rd_sel_i, rd_data_o : addressed readout, one cycle latency
//   err_o, sat_o                 : sticky overlapping-miss and counter-saturated flags
module cache_perf_monitor #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 32,
  parameter int LAT_W = 16,
  localparam int RD_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req_valid_i,
  input  logic [NUM_CH-1:0] req_ready_i,
  input  logic [NUM_CH-1:0] hit_i,
  input  logic [NUM_CH-1:0] miss_i,
  input  logic [NUM_CH-1:0] resp_valid_i,
  input  logic              clear_i,
  input  logic              freeze_i,
  input  logic [RD_W-1:0]   rd_ch_i,
  input  logic [2:0]        rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH-1:0] err_o,
  output logic [NUM_CH-1:0] sat_o
);
  logic [NUM_CH-1:0][CNT_W-1:0] acc_v, hit_v, miss_v, stall_v, tot_v;
  logic [NUM_CH-1:0][LAT_W-1:0] max_v;
  logic [NUM_CH-1:0] st_v;
  logic [CNT_W-1:0] rd_d;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic a, s, h, m, rs, st, nst, cl, ld, run, err, sat;
    logic [CNT_W-1:0] acc, hit, miss, stall, tot;
    logic [LAT_W-1:0] mx, tmr;
    logic [CNT_W:0] tot_n;
    assign a = req_valid_i[c] & req_ready_i[c];
    assign s = req_valid_i[c] & ~req_ready_i[c];
    assign m = a & miss_i[c];
    assign h = a & hit_i[c] & ~miss_i[c];
    assign rs = resp_valid_i[c];
    always_ff @(posedge clk_i) st <= (rst_i || clear_i) ? 1'b0 : nst;
    always_comb nst = st ? (~rs | m) : m;
    // cl closes the pending miss; ld (re)starts the timer; a miss in WAIT without response keeps it running
    always_comb begin
      cl = st & rs;
      ld = m & (~st | rs);
      run = st & ~rs;
    end
    // the timer runs regardless of freeze so latency stays correct across a freeze window
    always_ff @(posedge clk_i)
      if (rst_i || clear_i) tmr <= '0;
      else tmr <= ld ? LAT_W'(1) : run ? tmr + LAT_W'(~&tmr) : '0;
    assign tot_n = {1'b0, tot} + (CNT_W+1)'(tmr);
    always_ff @(posedge clk_i)
      if (rst_i || clear_i) begin
        acc <= '0;
        hit <= '0;
        miss <= '0;
        stall <= '0;
        tot <= '0;
        mx <= '0;
        err <= 1'b0;
        sat <= 1'b0;
      end else if (!freeze_i) begin
        if (a && !(&acc)) acc <= acc + CNT_W'(1);
        if (h && !(&hit)) hit <= hit + CNT_W'(1);
        if (m && !(&miss)) miss <= miss + CNT_W'(1);
        if (s && !(&stall)) stall <= stall + CNT_W'(1);
        if (cl) tot <= tot_n[CNT_W] ? '1 : tot_n[CNT_W-1:0];
        if (cl && tmr > mx) mx <= tmr;
        if (run && m) err <= 1'b1;
        if ((a && &acc) || (h && &hit) || (m && &miss) || (s && &stall) || (cl && tot_n[CNT_W])) sat <= 1'b1;
      end
    assign acc_v[c] = acc;
    assign hit_v[c] = hit;
    assign miss_v[c] = miss;
    assign stall_v[c] = stall;
    assign tot_v[c] = tot;
    assign max_v[c] = mx;
    assign st_v[c] = st;
    assign err_o[c] = err;
    assign sat_o[c] = sat;
  end
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_ch_i == RD_W'(i))
        rd_d = rd_sel_i == 3'd0 ? acc_v[i] :
               rd_sel_i == 3'd1 ? hit_v[i] :
               rd_sel_i == 3'd2 ? miss_v[i] :
               rd_sel_i == 3'd3 ? stall_v[i] :
               rd_sel_i == 3'd4 ? tot_v[i] :
               rd_sel_i == 3'd5 ? CNT_W'(max_v[i]) :
               rd_sel_i == 3'd6 ? CNT_W'({sat_o[i], err_o[i], st_v[i]}) : '0;
  end
  always_ff @(posedge clk_i) rd_data_o <= rst_i ? '0 : rd_d;
endmodule

// File: tb/tb_cache_perf_monitor.sv
// tb_cache_perf_monitor: scoreboard bench for cache_perf_monitor (default build and CNT_W=4/LAT_W=3 build)
module tb_cache_perf_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rv = '0, rr = '0, hi = '0, mi = '0, rs = '0;
  logic clr = 1'b0, frz = 1'b0;
  logic [1:0] rd_ch = '0;
  logic [2:0] rd_sel = '0;
  logic [31:0] d0;
  logic [3:0] d1;
  logic [2:0] err0, sat0, err1, sat1;
  int checks = 0, failures = 0;
  logic [31:0] expq[$], obsq[$];
  string nmq[$];
  logic [31:0] e, o;
  string n;
  always #5 clk = ~clk;
  cache_perf_monitor u0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_ready_i(rr), .hit_i(hi), .miss_i(mi),
    .resp_valid_i(rs), .clear_i(clr), .freeze_i(frz), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
    .rd_data_o(d0), .err_o(err0), .sat_o(sat0)
  );
  cache_perf_monitor #(.CNT_W(4), .LAT_W(3)) u1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_ready_i(rr), .hit_i(hi), .miss_i(mi),
    .resp_valid_i(rs), .clear_i(clr), .freeze_i(frz), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
    .rd_data_o(d1), .err_o(err1), .sat_o(sat1)
  );
  task cyc;
    @(posedge clk);
    #1;
  endtask
  task idle(input int k);
    repeat (k) cyc();
  endtask
  task ev(input int ch, input bit v, input bit r, input bit h, input bit m, input bit p);
    logic [2:0] b;
    b = 3'b001 << ch;
    rv = {3{v}} & b;
    rr = {3{r}} & b;
    hi = {3{h}} & b;
    mi = {3{m}} & b;
    rs = {3{p}} & b;
    cyc();
    rv = '0;
    rr = '0;
    hi = '0;
    mi = '0;
    rs = '0;
  endtask
  task rd(input bit d, input int ch, input int sel, input logic [31:0] x, input string nm);
    rd_ch = 2'(ch);
    rd_sel = 3'(sel);
    expq.push_back(x);
    nmq.push_back(nm);
    cyc();
    obsq.push_back(d ? 32'(d1) : d0);
  endtask
  task test_reset;
    idle(3);
    checks++;
    if (d0 !== 32'd0 || d1 !== 4'd0) begin failures++; $display("FAIL reset_rd_data: got %0h/%0h expected 0", d0, d1); end
    checks++;
    if ({err0, sat0, err1, sat1} !== 12'd0) begin failures++; $display("FAIL reset_flags: got %b expected 0", {err0, sat0, err1, sat1}); end
    rst = 1'b0;
    idle(1);
    rd(0, 0, 0, 0, "reset_ch0_acc");
    rd(0, 2, 6, 0, "reset_ch2_status");
    rd(1, 1, 1, 0, "reset_u1_hit");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
  endtask
  task test_hit_miss;
    for (int i = 0; i < 5; i++) begin
      ev(1, 1, 1, 1, 0, 0);
      ev(1, 1, 1, 0, 1, 0);
      idle(3);
      ev(1, 0, 0, 0, 0, 1);
    end
    rd(0, 1, 0, 10, "hm_acc");
    rd(0, 1, 1, 5, "hm_hit");
    rd(0, 1, 2, 5, "hm_miss");
    rd(0, 1, 3, 0, "hm_stall");
    rd(0, 1, 4, 20, "hm_lat_tot");
    rd(0, 1, 5, 4, "hm_lat_max");
    rd(0, 1, 6, 0, "hm_status");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
    checks++;
    if (err0 !== 3'b000) begin failures++; $display("FAIL hm_err: got %b expected 000", err0); end
  endtask
  task test_stall;
    for (int i = 0; i < 6; i++) ev(0, 1, 0, 0, 0, 0);
    ev(0, 1, 1, 1, 0, 0);
    rd(0, 0, 3, 6, "st_stall");
    rd(0, 0, 0, 1, "st_acc");
    rd(0, 0, 1, 1, "st_hit");
    rd(0, 0, 2, 0, "st_miss");
    rd(0, 2, 0, 0, "st_ch2_acc");
    rd(0, 2, 3, 0, "st_ch2_stall");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
  endtask
  task test_back_to_back;
    ev(2, 1, 1, 0, 1, 0);
    idle(2);
    ev(2, 1, 1, 0, 1, 1);
    idle(6);
    ev(2, 0, 0, 0, 0, 1);
    rd(0, 2, 4, 10, "b2b_lat_tot");
    rd(0, 2, 5, 7, "b2b_lat_max");
    rd(0, 2, 2, 2, "b2b_miss");
    rd(0, 2, 6, 0, "b2b_status");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
  endtask
  task test_overlap_clear;
    ev(0, 1, 1, 0, 1, 0);
    idle(2);
    ev(0, 1, 1, 0, 1, 0);
    rd(0, 0, 2, 2, "ov_miss");
    rd(0, 0, 0, 3, "ov_acc");
    rd(0, 0, 6, 3, "ov_status");
    idle(3);
    checks++;
    if (err0 !== 3'b001) begin failures++; $display("FAIL ov_err_sticky: got %b expected 001", err0); end
    clr = 1'b1;
    ev(0, 1, 1, 1, 0, 0);
    clr = 1'b0;
    rd(0, 0, 0, 0, "clr_acc");
    rd(0, 0, 2, 0, "clr_miss");
    rd(0, 0, 6, 0, "clr_status");
    rd(0, 1, 4, 0, "clr_ch1_lat_tot");
    rd(0, 2, 5, 0, "clr_ch2_lat_max");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
    checks++;
    if (err0 !== 3'b000) begin failures++; $display("FAIL clr_err: got %b expected 000", err0); end
  endtask
  task test_freeze;
    ev(1, 1, 1, 1, 0, 0);
    ev(1, 1, 1, 0, 1, 0);
    frz = 1'b1;
    ev(1, 1, 1, 0, 1, 0);
    ev(1, 1, 1, 1, 0, 0);
    ev(1, 1, 1, 1, 0, 0);
    ev(1, 0, 0, 0, 0, 1);
    frz = 1'b0;
    rd(0, 1, 0, 2, "fz_acc");
    rd(0, 1, 1, 1, "fz_hit");
    rd(0, 1, 2, 1, "fz_miss");
    rd(0, 1, 4, 0, "fz_lat_tot");
    rd(0, 1, 5, 0, "fz_lat_max");
    rd(0, 1, 6, 0, "fz_status");
    rd(0, 3, 0, 0, "fz_bad_ch");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
    checks++;
    if (err0 !== 3'b000) begin failures++; $display("FAIL fz_err: got %b expected 000", err0); end
  endtask
  task test_saturation;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) ev(1, 1, 1, 1, 0, 0);
    ev(2, 1, 1, 0, 1, 0);
    idle(11);
    ev(2, 0, 0, 0, 0, 1);
    rd(1, 1, 1, 15, "sat_u1_hit");
    rd(1, 1, 0, 15, "sat_u1_acc");
    rd(1, 1, 6, 4, "sat_u1_status");
    rd(0, 1, 1, 20, "sat_u0_hit");
    rd(1, 2, 5, 7, "sat_u1_lat_max");
    rd(1, 2, 4, 7, "sat_u1_lat_tot");
    rd(0, 2, 5, 12, "sat_u0_lat_max");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
    checks++;
    if (sat1 !== 3'b010) begin failures++; $display("FAIL sat_u1_flag: got %b expected 010", sat1); end
    checks++;
    if (sat0 !== 3'b000) begin failures++; $display("FAIL sat_u0_flag: got %b expected 000", sat0); end
  endtask
  task test_reset_mid_miss;
    ev(0, 1, 1, 0, 1, 0);
    idle(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ev(0, 0, 0, 0, 0, 1);
    rd(0, 0, 2, 0, "rmm_miss");
    rd(0, 0, 4, 0, "rmm_lat_tot");
    rd(0, 0, 6, 0, "rmm_status");
    rd(0, 1, 0, 0, "rmm_ch1_acc");
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n = nmq.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %0d expected %0d", n, o, e); end
    end
  endtask
  initial begin
    test_reset();
    test_hit_miss();
    test_stall();
    test_back_to_back();
    test_overlap_clear();
    test_freeze();
    test_saturation();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
